sym_player: RTL
===============

Name: sym_player

Overview:
- Transmit-side driver for the 2-bit-input state machines (case, memory and gate versions). It plays a programmed word out as a sequence of 2-bit symbols on the FSM's `a` input.
- Each symbol is held a fixed number of cycles, MSB pair first, with a start/busy/done handshake toward the controlling logic or bench.
- The block replaces hand-written `#delay a=...` stimulus. It can optionally track the FSM it drives and flag any divergence.

Parameters:
- WORD_W, 16, width of the programmed word; must be even. Symbol count N = WORD_W/2.
- HOLD, 4, cycles each symbol is held on sym; must be >= 1.
- IDLE_SYM, 2'b00, value driven on sym when not playing.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request playback of word; sampled only in IDLE.
- abort  in  1  synchronous stop of playback; no done pulse.
- word  in  WORD_W  symbols to play; bits [WORD_W-1:WORD_W-2] go first.
- sym  out  2  registered symbol; connects to FSM input a.
- sym_idx  out  clog2(N) (min 1)  index of the symbol currently on sym.
- busy  out  1  high in PLAY.
- done  out  1  one-cycle pulse after the last symbol completes.
- state_in  in  3  FSM visible state code (saida); used only with the optional feature.
- mismatch  out  1  sticky divergence flag; constant 0 without the optional feature.

Behaviour:
- States: IDLE, PLAY, DONE (2-bit register).
- Reset: state=IDLE, sym=IDLE_SYM, sym_idx=0, busy=0, done=0, hold counter=0, shift register=0, mismatch=0. Reset has priority over everything, including mid-playback.
- IDLE:
  - sym=IDLE_SYM.
  - On the edge where start=1, shift register is loaded with word, hold counter=0, sym_idx=0, state goes to PLAY.
  - sym takes word[WORD_W-1:WORD_W-2] on that same edge, so the first symbol is visible the cycle after start.
- PLAY:
  - busy=1; hold counter increments each edge.
  - When the counter reaches HOLD-1 and more symbols remain: shift register shifts left by 2, counter=0, sym_idx+1, sym=next pair.
  - When the counter reaches HOLD-1 on the last symbol (sym_idx=N-1): state goes to DONE and sym=IDLE_SYM.
- Timing: start sampled at edge k puts symbol i on sym during cycles k+1+i*HOLD .. k+(i+1)*HOLD. done is high in cycle k+N*HOLD+1.
- DONE: done=1, busy=0, sym=IDLE_SYM; returns to IDLE on the next edge. start in DONE is ignored.
- start while busy: ignored; word changes are ignored after loading.
- abort (IDLE or PLAY): next edge gives state=IDLE, sym=IDLE_SYM, sym_idx=0, no done. Same-cycle abort and start in IDLE: abort wins, stays IDLE.
- HOLD=1: a new symbol every cycle; last symbol is followed directly by DONE.

Optional Feature:
- Macro SYM_PLAYER_CHK_EN.
- Defined:
  - Internal predictor register pred (3 bits, 8 encodings: states 0-6 plus internal 3*) is reset to 0 by reset and advanced every edge as f(pred, sym).
  - f:
    - 0: a∈{0,2}→1, 1→2, 3→5.
    - 1: a∈{0,1}→2, else→3.
    - 2: 0→0, 1→4, 2→3*, 3→3.
    - 3: 3→5, else→2.
    - 4: 0→0, else→3.
    - 5: 0→0, 3→6, else→3.
    - 6: 0→0, else→3.
    - 3*: 2→1, 3→3, else→2.
  - Visible code vis = 3 when pred=3*, else pred.
  - In any cycle with busy=1 and state_in≠vis, mismatch is set at the next edge and stays set until reset.
  - The driven FSM must be reset in the same cycle as this block.
- Undefined: no predictor logic; mismatch tied 0; state_in unused.

Test Plan:
- Reset then start with word=16'hB4C1, HOLD=4 → sym sequence 10,11,01,00,11,00,00,01, each for exactly 4 cycles starting the cycle after start; done pulses once at cycle start+33; busy low after.
- start held high during PLAY, word changed mid-play → sequence unchanged, no restart; one done only.
- abort asserted during symbol 3 → next cycle sym=00, busy=0, sym_idx=0, done never asserts; new start then plays from symbol 0.
- reset asserted mid-PLAY → all outputs return to reset values on that edge; subsequent start works normally.
- HOLD=1, word=16'hFFFF → sym=11 for 8 consecutive cycles, done in the 9th cycle after start.
- SYM_PLAYER_CHK_EN defined, case FSM connected with a shared reset, word=16'hB4C1 → mismatch stays 0; forcing state_in to 7 for one busy cycle → mismatch=1 from the next edge and held until reset.

Source files
------------

// File: rtl/sym_player.sv
// rtl/sym_player.sv - plays a programmed word as held 2-bit symbols with a start/busy/done handshake
// Optional SYM_PLAYER_CHK_EN: predicts the driven FSM's state and flags divergence on mismatch.
module sym_player #(
  parameter int         WORD_W   = 16,
  parameter int         HOLD     = 4,
  parameter logic [1:0] IDLE_SYM = 2'b00,
  localparam int        N        = WORD_W / 2,
  localparam int        IDX_W    = (N > 1) ? $clog2(N) : 1,
  localparam int        CNT_W    = (HOLD > 1) ? $clog2(HOLD) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word,
  output logic [1:0]        sym,
  output logic [IDX_W-1:0]  sym_idx,
  output logic              busy,
  output logic              done,
  input  logic [2:0]        state_in,
  output logic              mismatch
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t            state_q;
  logic [1:0]        sym_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] shreg_q;
  logic [WORD_W-1:0] shreg_d;
  logic              busy_q;
  logic              done_q;

  assign shreg_d = shreg_q << 2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sym_q   <= IDLE_SYM;
      idx_q   <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sym_q  <= IDLE_SYM;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start && !abort) begin
            state_q <= S_PLAY;
            shreg_q <= word;
            sym_q   <= word[WORD_W-1 -: 2];
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_PLAY: begin
          if (abort) begin
            state_q <= S_IDLE;
            sym_q   <= IDLE_SYM;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_W'(HOLD - 1)) begin
            cnt_q <= '0;
            if (idx_q == IDX_W'(N - 1)) begin
              state_q <= S_DONE;
              sym_q   <= IDLE_SYM;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              shreg_q <= shreg_d;
              sym_q   <= shreg_d[WORD_W-1 -: 2];
              idx_q   <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          // Single-cycle state: start is deliberately not sampled here.
          state_q <= S_IDLE;
          sym_q   <= IDLE_SYM;
          idx_q   <= '0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          sym_q   <= IDLE_SYM;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sym     = sym_q;
  assign sym_idx = idx_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef SYM_PLAYER_CHK_EN
  // Code 7 stands for the internal 3* state, which the FSM shows as 3.
  localparam logic [2:0] P_3S = 3'd7;

  logic [2:0] pred_q;
  logic [2:0] pred_d;
  logic [2:0] vis;
  logic       mismatch_q;

  always_comb begin
    pred_d = 3'd0;
    case (pred_q)
      3'd0: pred_d = (sym_q == 2'd1) ? 3'd2 : (sym_q == 2'd3) ? 3'd5 : 3'd1;
      3'd1: pred_d = (sym_q[1] == 1'b0) ? 3'd2 : 3'd3;
      3'd2: pred_d = (sym_q == 2'd0) ? 3'd0 : (sym_q == 2'd1) ? 3'd4 :
                     (sym_q == 2'd2) ? P_3S : 3'd3;
      3'd3: pred_d = (sym_q == 2'd3) ? 3'd5 : 3'd2;
      3'd4: pred_d = (sym_q == 2'd0) ? 3'd0 : 3'd3;
      3'd5: pred_d = (sym_q == 2'd0) ? 3'd0 : (sym_q == 2'd3) ? 3'd6 : 3'd3;
      3'd6: pred_d = (sym_q == 2'd0) ? 3'd0 : 3'd3;
      default: pred_d = (sym_q == 2'd2) ? 3'd1 : (sym_q == 2'd3) ? 3'd3 : 3'd2;
    endcase
  end

  assign vis = (pred_q == P_3S) ? 3'd3 : pred_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_q     <= 3'd0;
      mismatch_q <= 1'b0;
    end else begin
      pred_q <= pred_d;
      if (busy_q && (state_in != vis)) mismatch_q <= 1'b1;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_state_in;
  assign unused_state_in = ^state_in;
  assign mismatch        = 1'b0;
`endif

endmodule
